// File: rtl/model_scalar_float_arbiter_pkg.sv
// Shared types for the scalar float unit arbiter: FSM states and
// the round-robin pick used by model_round_robin_selector.
package model_ntm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_e;

    localparam int RR_MAX = 16;
    localparam int RR_IW  = 4;

    typedef struct packed {
        logic             found;
        logic [RR_IW-1:0] idx;
    } rr_sel_t;

    // First set bit of pending at or after pointer, wrapping at n.
    function automatic rr_sel_t rr_select(
        input logic [RR_MAX-1:0] pending,
        input logic [RR_IW-1:0]  pointer,
        input int                n
    );
        rr_sel_t r;
        int      k;
        r = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            k = int'(pointer) + i;
            if (k >= n) begin
                k = k - n;
            end
            if (i < n && !r.found && pending[k[RR_IW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = k[RR_IW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/model_scalar_float_arbiter_if.sv
// Requester and float-unit bus of the scalar float arbiter.
// slave: arbiter side; master: requesters plus the shared unit.
interface model_scalar_float_arbiter_if #(
    parameter int DATA_SIZE  = 64,
    parameter int REQUESTERS = 4
) ();

    localparam int GW = $clog2(REQUESTERS);

    logic [REQUESTERS-1:0]           REQ_START;
    logic [REQUESTERS*DATA_SIZE-1:0] REQ_DATA_A_IN;
    logic [REQUESTERS*DATA_SIZE-1:0] REQ_DATA_B_IN;
    logic [REQUESTERS-1:0]           REQ_READY;
    logic [DATA_SIZE-1:0]            REQ_DATA_OUT;
    logic [REQUESTERS-1:0]           REQ_PENDING;
    logic                            UNIT_START;
    logic                            UNIT_READY;
    logic [DATA_SIZE-1:0]            UNIT_DATA_A_OUT;
    logic [DATA_SIZE-1:0]            UNIT_DATA_B_OUT;
    logic [DATA_SIZE-1:0]            UNIT_DATA_IN;
    logic                            BUSY;
    logic [GW-1:0]                   GRANT;

    modport slave (
        input  REQ_START,
        input  REQ_DATA_A_IN,
        input  REQ_DATA_B_IN,
        output REQ_READY,
        output REQ_DATA_OUT,
        output REQ_PENDING,
        output UNIT_START,
        input  UNIT_READY,
        output UNIT_DATA_A_OUT,
        output UNIT_DATA_B_OUT,
        input  UNIT_DATA_IN,
        output BUSY,
        output GRANT
    );

    modport master (
        output REQ_START,
        output REQ_DATA_A_IN,
        output REQ_DATA_B_IN,
        input  REQ_READY,
        input  REQ_DATA_OUT,
        input  REQ_PENDING,
        input  UNIT_START,
        output UNIT_READY,
        input  UNIT_DATA_A_OUT,
        input  UNIT_DATA_B_OUT,
        output UNIT_DATA_IN,
        input  BUSY,
        input  GRANT
    );

endinterface

// File: rtl/model_scalar_float_arbiter_selector.sv
// Combinational round-robin pick: first pending index at or after
// pointer_i. Ports: pending_i, pointer_i -> found_o, index_o.
module model_round_robin_selector
    import model_ntm_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  pending_i,
    input  logic [GW-1:0] pointer_i,
    output logic          found_o,
    output logic [GW-1:0] index_o
);

    logic [RR_MAX-1:0] pend_w;
    logic [RR_IW-1:0]  ptr_w;
    rr_sel_t           sel;

    always_comb begin
        pend_w           = '0;
        pend_w[N-1:0]    = pending_i;
        ptr_w            = '0;
        ptr_w[GW-1:0]    = pointer_i;
        sel              = rr_select(pend_w, ptr_w, N);
    end

    // Range guard keeps the index legal for non-power-of-two N.
    assign found_o = sel.found && (32'(sel.idx) < N);
    assign index_o = sel.idx[GW-1:0];

endmodule

// File: rtl/model_scalar_float_arbiter.sv
// Round-robin sequencer sharing one scalar float unit among requesters.
// Ports: CLK, RST (async active-low), bus (slave side of the arbiter bus).
module model_scalar_float_arbiter
    import model_ntm_arbiter_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int REQUESTERS   = 4
) (
    input logic                         CLK,
    input logic                         RST,
    model_scalar_float_arbiter_if.slave bus
);

    localparam int GW = $clog2(REQUESTERS);

    if (REQUESTERS < 2 || REQUESTERS > 16 || CONTROL_SIZE < 1) begin : g_bad_cfg
        $error("model_scalar_float_arbiter: unsupported parameters");
    end

    arb_state_e            state_q;
    logic [REQUESTERS-1:0] pend_q;
    logic [REQUESTERS-1:0] pend_d;
    logic [REQUESTERS-1:0] clr_d;
    logic [REQUESTERS-1:0] cap_d;
    logic [DATA_SIZE-1:0]  opa_q [REQUESTERS];
    logic [DATA_SIZE-1:0]  opb_q [REQUESTERS];
    logic [GW-1:0]         ptr_q;
    logic [GW-1:0]         ptr_d;
    logic [GW-1:0]         grant_q;
    logic                  ustart_q;
    logic [DATA_SIZE-1:0]  ua_q;
    logic [DATA_SIZE-1:0]  ub_q;
    logic [REQUESTERS-1:0] rdy_q;
    logic [DATA_SIZE-1:0]  res_q;
    logic                  sel_found;
    logic [GW-1:0]         sel_idx;

    model_round_robin_selector #(
        .N  (REQUESTERS),
        .GW (GW)
    ) u_sel (
        .pending_i (pend_q),
        .pointer_i (ptr_q),
        .found_o   (sel_found),
        .index_o   (sel_idx)
    );

    // A request is accepted when its slot is free or is being
    // retired this cycle; a new START wins over the DONE clear.
    always_comb begin
        clr_d = '0;
        if (state_q == DONE) begin
            clr_d[grant_q] = 1'b1;
        end
        cap_d  = bus.REQ_START & (~pend_q | clr_d);
        pend_d = (pend_q & ~clr_d) | bus.REQ_START;
    end

    always_comb begin
        ptr_d = grant_q + GW'(1);
        if (grant_q == GW'(REQUESTERS - 1)) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < REQUESTERS; i++) begin
                opa_q[i] <= '0;
                opb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (cap_d[i]) begin
                    opa_q[i] <= bus.REQ_DATA_A_IN[i*DATA_SIZE +: DATA_SIZE];
                    opb_q[i] <= bus.REQ_DATA_B_IN[i*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            ustart_q <= 1'b0;
            ua_q     <= '0;
            ub_q     <= '0;
            rdy_q    <= '0;
            res_q    <= '0;
        end else begin
            pend_q   <= pend_d;
            ustart_q <= 1'b0;
            rdy_q    <= '0;
            unique case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        grant_q  <= sel_idx;
                        ua_q     <= opa_q[sel_idx];
                        ub_q     <= opb_q[sel_idx];
                        ustart_q <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                // UNIT_READY is not looked at here on purpose.
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.UNIT_READY) begin
                        res_q          <= bus.UNIT_DATA_IN;
                        rdy_q[grant_q] <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.REQ_READY       = rdy_q;
    assign bus.REQ_DATA_OUT    = res_q;
    assign bus.REQ_PENDING     = pend_q;
    assign bus.UNIT_START      = ustart_q;
    assign bus.UNIT_DATA_A_OUT = ua_q;
    assign bus.UNIT_DATA_B_OUT = ub_q;
    assign bus.BUSY            = (state_q != IDLE);
    assign bus.GRANT           = grant_q;

endmodule

// File: doc/model_scalar_float_arbiter.md
Name: model_scalar_float_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one scalar float unit (multiplier or divider, START/READY handshake) among REQUESTERS tensor/vector controllers.
- Sits between the tensor-level sequencers, such as the tensor inverse pipeline, and a single model_scalar_float_multiplier or model_scalar_float_divider instance, so that larger blocks do not each instantiate their own float units.
- Latches each request and its operands, issues one operation at a time to the unit, and returns the result to the originating requester.

Parameters:
- DATA_SIZE, 64, operand/result width.
- CONTROL_SIZE, 4, passed through; unused internally.
- REQUESTERS, 4, number of requester ports (2..16).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ_START  in  REQUESTERS  per-requester one-cycle request pulse.
- REQ_DATA_A_IN  in  REQUESTERS*DATA_SIZE  operand A; slice i belongs to requester i.
- REQ_DATA_B_IN  in  REQUESTERS*DATA_SIZE  operand B; slice i belongs to requester i.
- REQ_READY  out  REQUESTERS  per-requester one-cycle completion pulse.
- REQ_DATA_OUT  out  DATA_SIZE  result; valid only while some REQ_READY bit is high.
- REQ_PENDING  out  REQUESTERS  latched, not-yet-completed requests.
- UNIT_START  out  1  one-cycle start to the shared float unit.
- UNIT_READY  in  1  completion from the shared float unit.
- UNIT_DATA_A_OUT  out  DATA_SIZE  operand A to the unit.
- UNIT_DATA_B_OUT  out  DATA_SIZE  operand B to the unit.
- UNIT_DATA_IN  in  DATA_SIZE  result from the unit.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- GRANT  out  $clog2(REQUESTERS)  index of the requester currently being served.

Behaviour:
- Reset (RST=0, asynchronous) forces all of the following:
  - all outputs to 0 (REQ_READY, REQ_DATA_OUT, REQ_PENDING, UNIT_START, UNIT_DATA_A_OUT, UNIT_DATA_B_OUT, BUSY, GRANT);
  - all operand latches to 0;
  - round-robin pointer to 0;
  - FSM to IDLE.
- Reset mid-operation discards all pending requests; a late UNIT_READY after release is ignored because the FSM is in IDLE.
- Request latch, per requester i:
  - REQ_START[i]=1 and pending[i]=0: set pending[i] and capture that requester's A/B slices at the same edge.
  - REQ_START[i]=1 and pending[i]=1: ignored. Operands are not overwritten and no second request is queued.
  - Completion clears pending[i] in the DONE cycle. A REQ_START[i] arriving in that same cycle is accepted as a new request (set wins over clear).
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any pending bit is set, choose the first pending index at or after the pointer (wrapping modulo REQUESTERS). Register GRANT and drive UNIT_DATA_A_OUT/UNIT_DATA_B_OUT from that requester's latches. Go to ISSUE.
  - ISSUE: UNIT_START=1 for exactly this one cycle. Operands stay stable from ISSUE until DONE. Go to WAIT.
  - WAIT: hold until UNIT_READY is sampled high, then capture UNIT_DATA_IN into REQ_DATA_OUT and go to DONE.
  - DONE: REQ_READY[GRANT]=1 for one cycle, clear pending[GRANT], set pointer=GRANT+1 (wrapping), go to IDLE.
- UNIT_READY handling:
  - UNIT_READY during ISSUE is ignored; the unit must respond no earlier than the cycle after START.
  - UNIT_READY is ignored in IDLE and DONE.
- Latency:
  - REQ_START at edge t gives UNIT_START at t+2.
  - If UNIT_READY is sampled at edge u, REQ_READY is high in the cycle after u.
  - Overhead per operation is 4 cycles plus the unit latency; no back-to-back overlap.
- Fairness: a continuously re-requesting requester cannot be served twice while another request is pending.
- REQ_DATA_OUT holds its last value between completions.

Decomposition:
- Shared package model_ntm_arbiter_pkg contains:
  - FSM state enum (IDLE, ISSUE, WAIT, DONE);
  - function rr_select(pending, pointer), returning the first set bit at or after the pointer with wrap, plus a found flag.
- One sub-module is natural: model_round_robin_selector, a combinational priority rotation reused by later arbiters. The request latches and FSM stay in the top module.

Test Plan:
- Single request: REQUESTERS=4, unit mock with 3-cycle latency, multiplier semantics. REQ_START[2] with A=2.0, B=3.0 -> UNIT_START 2 cycles later; REQ_READY[2] pulses once with REQ_DATA_OUT=6.0; GRANT=2; BUSY low afterwards.
- Simultaneous requests: REQ_START=4'b1011 in one cycle -> served in order 0, 1, 3, each with its own operands; exactly one REQ_READY bit per completion.
- Fairness: requester 0 re-pulses immediately after each of its completions while requester 1 is pending -> grant sequence 0, 1, 0, 1.
- Duplicate START: REQ_START[1] pulsed with A=1.0, then with A=5.0 while still pending -> only one completion, computed with A=1.0.
- Boundary: REQ_START[0] pulsed in the same cycle as its own REQ_READY[0] -> a second completion follows. UNIT_READY forced high during ISSUE -> ignored; FSM waits for the real response.
- Reset mid-WAIT: RST low for 1 cycle while 2 requests are pending -> all outputs 0, REQ_PENDING=0; the mock's late UNIT_READY produces no REQ_READY.
